instr_loader: RTL and testbench

Sequential writer that fills the byte-wide instruction memory from a stream of 32-bit instruction words. The instruction fetch path reads byte-addressed, word-aligned, big-endian words (byte at word address N is instr[31:24], N+3 is instr[7:0]). This block produces exactly that layout. It sits between a boot/host word source (valid/ready) and the memory write port, one byte per cycle.

---
 rtl/instr_loader.sv | 109 ++++++++++
 tb/tb_instr_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// instr_loader: writes a stream of 32-bit instruction words into a byte-wide
// instruction memory, one byte per cycle, big-endian within each word.
module instr_loader #(
  parameter int unsigned ADDR_WIDTH        = 5,
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned INSTRUCTION_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic [ADDR_WIDTH-2:0]        word_count,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INSTRUCTION_WIDTH-1:0] in_word,
  output logic                         mem_we,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

  localparam logic [ADDR_WIDTH-2:0] RemOne = (ADDR_WIDTH-1)'(1);

  state_e                         state_q, state_d;
  logic [ADDR_WIDTH-1:0]          ptr_q, ptr_d;
  logic [ADDR_WIDTH-2:0]          remaining_q, remaining_d;
  logic [1:0]                     byte_idx_q, byte_idx_d;
  logic [INSTRUCTION_WIDTH-1:0]   word_q, word_d;

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      remaining_q <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
    end
  end

  // Next-state logic for the session sequencer.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          // Base is forced word-aligned so every word lands on a fetch boundary.
          ptr_d       = {base_addr[ADDR_WIDTH-1:2], 2'b00};
          remaining_d = word_count;
          state_d     = (word_count == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        if (in_valid) begin
          word_d     = in_word;
          byte_idx_d = 2'd0;
          state_d    = StWrite;
        end
      end
      StWrite: begin
        // ptr wraps silently at the top of memory.
        ptr_d      = ptr_q + ADDR_WIDTH'(1);
        byte_idx_d = byte_idx_q + 2'd1;
        if (byte_idx_q == 2'd3) begin
          remaining_d = remaining_q - RemOne;
          state_d     = (remaining_q == RemOne) ? StDone : StLoad;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    in_ready  = (state_q == StLoad);
    busy      = (state_q == StLoad) || (state_q == StWrite);
    done      = (state_q == StDone);
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == StWrite) begin
      mem_we   = 1'b1;
      mem_addr = ptr_q;
      unique case (byte_idx_q)
        2'd0: mem_wdata = word_q[3*DATA_WIDTH +: DATA_WIDTH];
        2'd1: mem_wdata = word_q[2*DATA_WIDTH +: DATA_WIDTH];
        2'd2: mem_wdata = word_q[1*DATA_WIDTH +: DATA_WIDTH];
        default: mem_wdata = word_q[0 +: DATA_WIDTH];
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: cycle-level vector table plus hand-written
// sequences for wrap-around, backpressure and mid-write reset.
module tb_instr_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  base_addr;
  logic [3:0]  word_count;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  // Byte memory fed by the write port; untouched locations read 0xFF.
  logic [7:0] mem [32] = '{default: 8'hFF};

  instr_loader #(
    .ADDR_WIDTH       (5),
    .DATA_WIDTH       (8),
    .INSTRUCTION_WIDTH(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .word_count(word_count),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  typedef struct packed {
    logic        start;
    logic [4:0]  base;
    logic [3:0]  cnt;
    logic        valid;
    logic [31:0] word;
    logic        rdy;
    logic        we;
    logic [4:0]  addr;
    logic [7:0]  data;
    logic        bsy;
    logic        dn;
  } vec_t;

  vec_t vecs [16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic rdy, input logic we, input logic [4:0] addr,
                     input logic [7:0] data, input logic bsy, input logic dn);
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, busy, done} !== {rdy, we, addr, data, bsy, dn}) begin
      errors++;
      $display("FAIL %s: got rdy=%b we=%b addr=%h data=%h busy=%b done=%b, required rdy=%b we=%b addr=%h data=%h busy=%b done=%b",
               name, in_ready, mem_we, mem_addr, mem_wdata, busy, done, rdy, we, addr, data, bsy,
               dn);
    end
  endtask

  task automatic chk_word(input string name, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] got;
    got = {mem[a], mem[5'(a + 5'd1)], mem[5'(a + 5'd2)], mem[5'(a + 5'd3)]};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: fetched %h at %h, required %h", name, got, a, exp);
    end
  endtask

  task automatic chk_byte(input string name, input logic [4:0] a, input logic [7:0] exp);
    checks++;
    if (mem[a] !== exp) begin
      errors++;
      $display("FAIL %s: mem[%h]=%h, required %h", name, a, mem[a], exp);
    end
  endtask

  // One accepted word written as four bytes from address a; checks each byte cycle.
  task automatic write_burst(input string name, input logic [31:0] w, input logic [4:0] a);
    logic [7:0] b;
    for (int k = 0; k < 4; k++) begin
      b = 8'(w >> (24 - 8 * k));
      chk(name, 1'b0, 1'b1, 5'(a + 5'(k)), b, 1'b1, 1'b0);
      step();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; in_valid = 1'b0; in_word = '0;

    // Outputs are all low while reset is held.
    #2;
    chk("reset", 1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0);
    step();
    chk("reset_held", 1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;

    // start, base, cnt, valid, word | rdy, we, addr, data, busy, done
    vecs[0]  = {1'b1, 5'h00, 4'd1, 1'b0, 32'h0,        1'b1, 1'b0, 5'h00, 8'h00, 1'b1, 1'b0};
    vecs[1]  = {1'b0, 5'h00, 4'd0, 1'b1, 32'h12345678, 1'b0, 1'b1, 5'h00, 8'h12, 1'b1, 1'b0};
    vecs[2]  = {1'b0, 5'h00, 4'd0, 1'b0, 32'h0,        1'b0, 1'b1, 5'h01, 8'h34, 1'b1, 1'b0};
    vecs[3]  = {1'b0, 5'h00, 4'd0, 1'b0, 32'h0,        1'b0, 1'b1, 5'h02, 8'h56, 1'b1, 1'b0};
    vecs[4]  = {1'b0, 5'h00, 4'd0, 1'b0, 32'h0,        1'b0, 1'b1, 5'h03, 8'h78, 1'b1, 1'b0};
    vecs[5]  = {1'b0, 5'h00, 4'd0, 1'b0, 32'h0,        1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b1};
    vecs[6]  = {1'b0, 5'h00, 4'd0, 1'b1, 32'h0,        1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0};
    vecs[7]  = {1'b1, 5'h06, 4'd1, 1'b0, 32'h0,        1'b1, 1'b0, 5'h00, 8'h00, 1'b1, 1'b0};
    vecs[8]  = {1'b0, 5'h00, 4'd0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 5'h04, 8'hDE, 1'b1, 1'b0};
    vecs[9]  = {1'b0, 5'h00, 4'd0, 1'b0, 32'h0,        1'b0, 1'b1, 5'h05, 8'hAD, 1'b1, 1'b0};
    vecs[10] = {1'b0, 5'h00, 4'd0, 1'b0, 32'h0,        1'b0, 1'b1, 5'h06, 8'hBE, 1'b1, 1'b0};
    vecs[11] = {1'b0, 5'h00, 4'd0, 1'b0, 32'h0,        1'b0, 1'b1, 5'h07, 8'hEF, 1'b1, 1'b0};
    vecs[12] = {1'b0, 5'h00, 4'd0, 1'b0, 32'h0,        1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b1};
    vecs[13] = {1'b0, 5'h00, 4'd0, 1'b0, 32'h0,        1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0};
    vecs[14] = {1'b1, 5'h0C, 4'd0, 1'b1, 32'h0,        1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b1};
    vecs[15] = {1'b0, 5'h00, 4'd0, 1'b1, 32'h0,        1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0};

    for (int i = 0; i < 16; i++) begin
      start = vecs[i].start; base_addr = vecs[i].base; word_count = vecs[i].cnt;
      in_valid = vecs[i].valid; in_word = vecs[i].word;
      step();
      chk($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].we, vecs[i].addr, vecs[i].data,
          vecs[i].bsy, vecs[i].dn);
    end
    start = 1'b0; in_valid = 1'b0;
    chk_word("fetch_single", 5'h00, 32'h12345678);
    chk_word("fetch_unaligned", 5'h04, 32'hDEADBEEF);

    // Wrap-around across the top of memory with two words.
    start = 1'b1; base_addr = 5'h1C; word_count = 4'd2;
    step();
    start = 1'b0;
    chk("wrap_load0", 1'b1, 1'b0, 5'h00, 8'h00, 1'b1, 1'b0);
    in_valid = 1'b1; in_word = 32'hAABBCCDD;
    step();
    in_valid = 1'b0;
    write_burst("wrap_w0", 32'hAABBCCDD, 5'h1C);
    chk("wrap_load1", 1'b1, 1'b0, 5'h00, 8'h00, 1'b1, 1'b0);
    in_valid = 1'b1; in_word = 32'h11223344;
    step();
    in_valid = 1'b0;
    write_burst("wrap_w1", 32'h11223344, 5'h00);
    chk("wrap_done", 1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b1);
    step();
    chk("wrap_idle", 1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0);
    chk_word("fetch_wrap_hi", 5'h1C, 32'hAABBCCDD);
    chk_word("fetch_wrap_lo", 5'h00, 32'h11223344);

    // Backpressure, with a stray start mid-session and another in DONE.
    start = 1'b1; base_addr = 5'h08; word_count = 4'd1;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_wait%0d", k), 1'b1, 1'b0, 5'h00, 8'h00, 1'b1, 1'b0);
      if (k == 1) begin
        start = 1'b1; base_addr = 5'h14; word_count = 4'd3;
      end
      step();
      start = 1'b0;
    end
    chk("bp_wait3", 1'b1, 1'b0, 5'h00, 8'h00, 1'b1, 1'b0);
    in_valid = 1'b1; in_word = 32'hCAFEF00D;
    step();
    in_valid = 1'b0;
    write_burst("bp_w", 32'hCAFEF00D, 5'h08);
    chk("bp_done", 1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b1);
    start = 1'b1; base_addr = 5'h00; word_count = 4'd0;
    step();
    start = 1'b0;
    chk("start_in_done_ignored", 1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0);
    step();
    chk("bp_idle", 1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0);
    chk_word("fetch_bp", 5'h08, 32'hCAFEF00D);
    chk_byte("stray_start_no_write", 5'h14, 8'hFF);

    // Reset after two byte writes: bytes 2 and 3 must never land.
    start = 1'b1; base_addr = 5'h10; word_count = 4'd1;
    step();
    start = 1'b0;
    chk("rst_load", 1'b1, 1'b0, 5'h00, 8'h00, 1'b1, 1'b0);
    in_valid = 1'b1; in_word = 32'h01020304;
    step();
    in_valid = 1'b0;
    chk("rst_b0", 1'b0, 1'b1, 5'h10, 8'h01, 1'b1, 1'b0);
    step();
    chk("rst_b1", 1'b0, 1'b1, 5'h11, 8'h02, 1'b1, 1'b0);
    step();
    rst = 1'b1;
    #1;
    chk("rst_immediate", 1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0);
    step();
    chk("rst_held2", 1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("rst_idle", 1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0);
    step();
    chk("rst_no_resume", 1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0);
    chk_byte("rst_kept0", 5'h10, 8'h01);
    chk_byte("rst_kept1", 5'h11, 8'h02);
    chk_byte("rst_lost2", 5'h12, 8'hFF);
    chk_byte("rst_lost3", 5'h13, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
